// File: rtl/uart_pkg.sv
// Shared types and default register map for the memory-mapped UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_0400;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_0404;
  localparam int          OVF_CLR_BIT   = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } mmio_req_t;

  typedef struct packed {
    logic overflow;
    logic full;
    logic busy;
  } tx_stat_t;
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count; full/empty come from the pre-edge count.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Store-driven UART transmitter: TX register feeds a byte FIFO, status register
// reports overflow/full/busy and clears overflow on a write with bit 2 set.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataIO,
  output logic        txd,
  output logic        busy
);
  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  mmio_req_t                   req;
  tx_stat_t                    stat;
  tx_state_t                   state, state_nx;
  logic [BW-1:0]               baud, baud_nx;
  logic [2:0]                  bit_idx, bit_idx_nx;
  logic [7:0]                  shreg, shreg_nx, fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        push, pop, full, empty, clr, overflow, baud_end;
  logic                        unused_wdata;

  assign req          = '{we: MemWriteM, adr: DataAdrM, wdata: WriteDataM};
  assign push         = req.we && (req.adr == TX_ADDR);
  assign clr          = req.we && (req.adr == STAT_ADDR) && req.wdata[OVF_CLR_BIT];
  assign unused_wdata = ^req.wdata[31:8];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req.wdata[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky until cleared; a push that finds the FIFO full is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             overflow <= 1'b0;
    else if (clr)           overflow <= 1'b0;
    else if (push && full)  overflow <= 1'b1;
  end

  assign busy       = (state != ST_IDLE) || (count != '0);
  assign stat       = '{overflow: overflow, full: full, busy: busy};
  assign ReadDataIO = (DataAdrM == STAT_ADDR) ? {29'b0, stat} : 32'b0;
  assign baud_end   = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  // txd decodes registered state so reset forces the line high without a clock.
  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    pop        = 1'b0;
    txd        = 1'b1;
    baud_nx    = (state == ST_IDLE || baud_end) ? '0 : baud + 1'b1;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = fifo_dout;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        txd = 1'b0;
        if (baud_end) begin
          state_nx   = ST_DATA;
          bit_idx_nx = '0;
        end
      end
      ST_DATA: begin
        txd = shreg[bit_idx];
        if (baud_end) begin
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (!empty) begin
            pop      = 1'b1;
            shreg_nx = fifo_dout;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_mmio_uart_tx;
  localparam int          CPB = 4;
  localparam logic [31:0] TXA = 32'h0000_0400;
  localparam logic [31:0] STA = 32'h0000_0404;

  logic        clk, reset, MemWriteM, txd, busy;
  logic [31:0] DataAdrM, WriteDataM, ReadDataIO;

  int         checks   = 0;
  int         failures = 0;
  int         push_at  = 1 << 30;
  logic [7:0] to_push [$];

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .TX_ADDR(TXA), .STAT_ADDR(STA)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .DataAdrM   (DataAdrM),
    .WriteDataM (WriteDataM),
    .ReadDataIO (ReadDataIO),
    .txd        (txd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    MemWriteM  = 1'b0;
    DataAdrM   = 32'h0;
    WriteDataM = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = 1'b1;
    DataAdrM   = a;
    WriteDataM = d;
    tick();
    bus_idle();
  endtask

  task automatic read_stat(input string tag, input logic [31:0] exp);
    DataAdrM = STA;
    #1;
    check(tag, ReadDataIO, exp);
    DataAdrM = 32'h0;
  endtask

  task automatic line(input string tag, input logic t, input logic b);
    check({tag, "_txd"},  {31'b0, txd},  {31'b0, t});
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
  endtask

  // Called in the first start-bit cycle; checks every cycle of the frame and
  // issues queued TX stores one per cycle from cycle push_at onward.
  task automatic frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    logic [7:0] nb;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k >= push_at && to_push.size() > 0) begin
        nb         = to_push.pop_front();
        MemWriteM  = 1'b1;
        DataAdrM   = TXA;
        WriteDataM = {24'hFFFF_FF, nb};
      end else begin
        bus_idle();
      end
      check($sformatf("%s[%0d]", tag, k), {31'b0, txd}, {31'b0, bits[k / CPB]});
      tick();
    end
    bus_idle();
  endtask

  initial begin
    bus_idle();
    reset = 1'b0;
    #1;
    line("rst", 1'b1, 1'b0);
    read_stat("rst_stat", 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    line("idle", 1'b1, 1'b0);

    // Single frame, upper data bits ignored
    store(TXA, 32'h0000_1255);
    line("push_edge", 1'b1, 1'b1);
    read_stat("busy_stat", 32'h1);
    tick();
    frame("f55", 8'h55);
    line("after55", 1'b1, 1'b0);

    // Back-to-back frames, second store lands on the pop edge
    store(TXA, 32'hA1);
    store(TXA, 32'h3C);
    frame("fA1", 8'hA1);
    frame("f3C", 8'h3C);
    line("after3C", 1'b1, 1'b0);

    // Six stores: one popped, four queued, sixth dropped
    store(TXA, 32'h11);
    store(TXA, 32'h22);
    to_push = '{8'h33, 8'h44, 8'h55, 8'h66};
    push_at = 0;
    frame("f11", 8'h11);
    push_at = 1 << 30;
    read_stat("ovf_refill", 32'h5);
    frame("f22", 8'h22);
    frame("f33", 8'h33);
    frame("f44", 8'h44);
    frame("f55b", 8'h55);
    line("after6", 1'b1, 1'b0);
    read_stat("ovf_idle", 32'h4);

    // Overflow clears only with bit 2; stores elsewhere do nothing
    store(STA, 32'hFFFF_FFFB);
    read_stat("no_clr", 32'h4);
    store(STA, 32'h4);
    read_stat("clr", 32'h0);
    store(32'h0000_0100, 32'h77);
    for (int i = 0; i < 3; i++) begin
      line($sformatf("other%0d", i), 1'b1, 1'b0);
      tick();
    end

    // Push coinciding with the STOP-end pop while two bytes are queued
    store(TXA, 32'h81);
    tick();
    to_push = '{8'h12, 8'h34, 8'h56};
    push_at = 37;
    frame("f81", 8'h81);
    to_push = '{8'h78, 8'h9A, 8'hBC};
    push_at = 0;
    frame("f12", 8'h12);
    push_at = 1 << 30;
    frame("f34", 8'h34);
    frame("f56", 8'h56);
    frame("f78", 8'h78);
    frame("f9A", 8'h9A);
    line("after_pp", 1'b1, 1'b0);
    read_stat("pp_ovf", 32'h4);

    // Reset during data bit 3 with one byte still queued
    store(TXA, 32'hF0);
    store(TXA, 32'h5A);
    for (int k = 0; k < 18; k++) tick();
    line("pre_rst", 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    line("mid_rst", 1'b1, 1'b0);
    read_stat("mid_rst_stat", 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    line("post_rst", 1'b1, 1'b0);
    tick();
    line("post_rst2", 1'b1, 1'b0);
    store(TXA, 32'hC3);
    tick();
    frame("fC3", 8'hC3);
    line("afterC3", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 4, transmit byte FIFO entries (power of two, >=2).
REQ-003 Parameter TX_ADDR, default 32'h0000_0400, transmit data register address.
REQ-004 Parameter STAT_ADDR, default 32'h0000_0404, status/control register address.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 MemWriteM  input  1  memory-stage store strobe from cpu.
REQ-008 DataAdrM  input  32  memory-stage byte address from cpu.
REQ-009 WriteDataM  input  32  memory-stage store data from cpu.
REQ-010 ReadDataIO  output  32  status read data, combinational.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  high while FIFO non-empty or frame in progress.

Function
REQ-013 Store with MemWriteM=1 and DataAdrM==TX_ADDR SHALL push WriteDataM[7:0] into FIFO at that edge if FIFO not full; bits [31:8] ignored.
REQ-014 Push while full SHALL be dropped and SHALL set sticky overflow flag; FIFO contents unchanged.
REQ-015 Store to STAT_ADDR with WriteDataM[2]=1 SHALL clear overflow; other bits ignored; clear wins over simultaneous set is impossible (distinct addresses).
REQ-016 ReadDataIO SHALL equal {29'b0, overflow, full, busy} when DataAdrM==STAT_ADDR, else 32'b0, regardless of MemWriteM.
REQ-017 FSM states: IDLE, START, DATA, STOP; encoding implementation-defined.
REQ-018 IDLE: txd=1; if FIFO non-empty, pop head and go START at next edge.
REQ-019 Byte pushed at edge N into empty FIFO while IDLE SHALL drive txd=0 from edge N+1.
REQ-020 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, 3-bit bit index, then STOP.
REQ-022 STOP: txd=1 for CLKS_PER_BIT cycles; then START directly (pop) if FIFO non-empty, else IDLE; no extra idle cycle between back-to-back frames.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 Baud counter counts 0..CLKS_PER_BIT-1, wraps and restarts on every state/bit change.
REQ-025 Simultaneous push and pop on non-full FIFO SHALL both occur; count unchanged.
REQ-026 full = (count==FIFO_DEPTH); full is evaluated before the same-edge pop, so a push while full is dropped even with concurrent pop.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-028 busy = (state!=IDLE) || (count!=0).

Reset
REQ-029 On reset=0 immediately: txd=1, state=IDLE, count=0, pointers=0, overflow=0, baud counter=0, bit index=0.
REQ-030 Reset mid-frame SHALL abort the frame, discard FIFO, txd high asynchronously; ReadDataIO follows combinationally (busy=0, full=0, overflow=0).

Structure
REQ-031 Package uart_pkg SHALL hold FSM state enum and default TX_ADDR/STAT_ADDR constants.
REQ-032 One sub-module byte_fifo (parameter DEPTH; push, pop, din, dout, full, empty, count) SHALL implement the FIFO.
REQ-033 mmio_uart_tx SHALL connect alongside RAMMemory on the cpu data bus in the top level; address decode local to this block.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Store 32'h0000_1255 to TX_ADDR -> txd 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4; busy low after 40 cycles.
REQ-035 Stores 8'hA1, 8'h3C on consecutive cycles -> two frames, second start bit immediately after first stop, total 80 cycles busy.
REQ-036 Six stores back-to-back while idle -> first popped, four queued, sixth dropped: overflow=1, ReadDataIO at STAT_ADDR = 32'h5 after FIFO refilled; 5 frames sent.
REQ-037 Store 32'h4 to STAT_ADDR after overflow -> ReadDataIO bit2=0; store to other address (32'h0000_0100) -> no push, txd stays 1.
REQ-038 reset=0 during DATA bit 3 -> txd=1 same cycle, busy=0; after release, new store transmits full clean frame.
REQ-039 Push at same edge FSM pops while count=2 -> count stays 2; order of transmitted bytes matches store order.
